range_calc: RTL and testbench
=============================

RANGE_CALC -- requirements
Module: range_calc

Interface
REQ-001 SHALL have parameter N, default 8, the anchor coordinate width; the point coordinate width is N+2 and the radius width is N+1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have ports xK, yK, input, N each, signed two's-complement anchor coordinates.
REQ-005 SHALL have ports xP, yP, input, N+2 each, signed two's-complement point coordinates, the same format as the intersections outputs.
REQ-006 SHALL have port in_valid, input, 1, meaning the operands are valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-008 SHALL have port rK, output, N+1, the unsigned floor Euclidean distance, saturated.
REQ-009 SHALL have port ovf, output, 1, meaning rK was saturated.
REQ-010 SHALL have port out_valid, output, 1, meaning rK and ovf are valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer acceptance signal.

Function
REQ-012 SHALL accept operands on a rising edge where in_valid=1 and in_ready=1, capturing xK, yK, xP and yP; operands are ignored otherwise.
REQ-013 SHALL assert in_ready only in state IDLE, with no overlap of consecutive operations.
REQ-014 SHALL implement the FSM IDLE -> SQUARE -> ROOT -> DONE -> IDLE:
- IDLE -> SQUARE on accept.
- SQUARE -> ROOT after 1 cycle.
- ROOT -> DONE after exactly N+4 cycles.
- DONE -> IDLE on out_valid=1 and out_ready=1.
REQ-015 SHALL in SQUARE compute dx = xP - sign-extended xK and dy = yP - sign-extended yK at width N+3 signed, and register S = dx*dx + dy*dy at width 2N+7 unsigned, with no intermediate truncation.
REQ-016 SHALL in ROOT run a restoring integer square root yielding one result bit per cycle, MSB first, producing a root R of N+4 bits that equals floor(sqrt(S)).
REQ-017 SHALL on the ROOT -> DONE transition set rK = R and ovf = 0 if R <= 2^(N+1)-1, otherwise set rK = 2^(N+1)-1 and ovf = 1.
REQ-018 SHALL assert out_valid exactly N+5 rising edges after the accepting edge (13 for N=8), and assert it only in DONE.
REQ-019 SHALL hold rK, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_valid=0 and in_ready=1 on the edge after the out_valid and out_ready handshake completes.
REQ-021 SHALL hold rK and ovf at their last values outside DONE; they are only meaningful while out_valid=1.
REQ-022 SHALL produce a correct result when dx=dy=0: rK=0, ovf=0.
REQ-023 SHALL handle the full signed extremes of all coordinates without wrap.

Reset
REQ-024 SHALL on a rising edge with rst_n=0, in any state including mid-ROOT, force state=IDLE, out_valid=0, rK=0, ovf=0 and clear all datapath registers.
REQ-025 SHALL drive in_ready=1 on the first edge after rst_n returns to 1; no partial result SHALL ever be presented.
REQ-026 SHALL give rst_n priority over a simultaneous in_valid or out_ready.

Structure
REQ-027 SHALL place the default N, the derived widths (N+2, N+3, 2N+7, N+4) and the FSM state encoding in the shared package triloc_pkg.
REQ-028 SHALL implement the iterative root as sub-module isqrt, which has a start/busy/done interface, a 2N+7-bit radicand and an N+4-bit root; range_calc owns the handshake, the squares and the saturation.

Verification
REQ-029 SHALL cover: xK=0, yK=0, xP=3, yP=4 -> rK=5, ovf=0, out_valid 13 cycles after accept.
REQ-030 SHALL cover: xK=-16, yK=-111, xP=20, yP=-111 -> rK=36, ovf=0; then xK=0, yK=0, xP=10, yP=10 -> rK=14 (floor of 14.14).
REQ-031 SHALL cover: xK=-128, yK=-128, xP=511, yP=511 -> S=816642, R=903, rK=511, ovf=1.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> rK, ovf and out_valid stable, in_ready=0; with out_ready=1 -> in_ready=1 next cycle.
REQ-033 SHALL cover: rst_n=0 for 1 cycle during the 4th ROOT cycle -> out_valid=0, rK=0, ovf=0, in_ready=1 after release; a new operand (xP=5, yP=12 from origin) -> rK=13.
REQ-034 SHALL cover: in_valid held 1 continuously over two operand sets -> exactly two results, each in order, with the second accepted only after the first handshake.

Source files
------------

// File: rtl/triloc_pkg.sv
// Shared widths and FSM encoding for the range calculator and its square-root unit.
package triloc_pkg;

   localparam int unsigned N_DEF = 8;

   function automatic int unsigned pt_w(input int unsigned n);
      return n + 2;
   endfunction

   function automatic int unsigned diff_w(input int unsigned n);
      return n + 3;
   endfunction

   function automatic int unsigned sq_w(input int unsigned n);
      return 2 * n + 7;
   endfunction

   function automatic int unsigned root_w(input int unsigned n);
      return n + 4;
   endfunction

   localparam int unsigned PT_W   = pt_w(N_DEF);
   localparam int unsigned DIFF_W = diff_w(N_DEF);
   localparam int unsigned SQ_W   = sq_w(N_DEF);
   localparam int unsigned ROOT_W = root_w(N_DEF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQUARE = 2'd1,
      ROOT   = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/isqrt.sv
// Restoring integer square root, one result bit per cycle, MSB first.
module isqrt
   import triloc_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [sq_w(N)-1:0]     radicand,
   output logic                   busy,
   output logic                   done,
   output logic [root_w(N)-1:0]   root
);

   localparam int unsigned SW  = sq_w(N);
   localparam int unsigned RTW = root_w(N);
   localparam int unsigned CW  = $clog2(RTW + 1);
   localparam logic [SW-1:0] ONE_INIT = SW'(1) << (2 * (RTW - 1));

   logic [SW-1:0] op_q, res_q, one_q;
   logic [SW-1:0] op_c, res_c, one_c;
   logic [SW-1:0] op_n, res_n, one_n;
   logic [SW:0]   trial;
   logic [CW-1:0] cnt_q, cnt_c;
   logic          active;

   // The start cycle already performs the first iteration, and done/root expose
   // the final iteration combinationally so the caller can register the result
   // on the same edge that retires the last bit.
   always_comb begin
      active = start | busy;
      op_c   = start ? radicand : op_q;
      res_c  = start ? '0       : res_q;
      one_c  = start ? ONE_INIT : one_q;
      cnt_c  = start ? '0       : cnt_q;
      trial  = {1'b0, res_c} + {1'b0, one_c};
      if ({1'b0, op_c} >= trial) begin
         op_n  = op_c - trial[SW-1:0];
         res_n = (res_c >> 1) + one_c;
      end else begin
         op_n  = op_c;
         res_n = res_c >> 1;
      end
      one_n = one_c >> 2;
      done  = active && (cnt_c == CW'(RTW - 1));
      root  = res_n[RTW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q  <= '0;
         res_q <= '0;
         one_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
      end else if (active) begin
         op_q  <= op_n;
         res_q <= res_n;
         one_q <= one_n;
         cnt_q <= cnt_c + 1'b1;
         busy  <= !done;
      end
   end

endmodule

// File: rtl/range_calc.sv
// Floor Euclidean distance between an anchor and a point, saturated to N+1 bits,
// with a valid/ready handshake on both sides.
module range_calc
   import triloc_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic signed [N-1:0]        xK,
   input  logic signed [N-1:0]        yK,
   input  logic signed [pt_w(N)-1:0]  xP,
   input  logic signed [pt_w(N)-1:0]  yP,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [N:0]                 rK,
   output logic                       ovf,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int unsigned PW  = pt_w(N);
   localparam int unsigned DW  = diff_w(N);
   localparam int unsigned SW  = sq_w(N);
   localparam int unsigned RTW = root_w(N);

   state_t                state;
   logic signed [N-1:0]   xk_q, yk_q;
   logic signed [PW-1:0]  xp_q, yp_q;
   logic [SW-1:0]         s_q, s_c;
   logic signed [DW-1:0]  dx, dy;
   logic signed [2*DW-1:0] sqx, sqy;
   logic                  sq_start, sq_busy, sq_done, sat;
   logic [RTW-1:0]        root;
   logic [N:0]            rk_c;

   always_comb begin
      dx   = DW'(xp_q) - DW'(xk_q);
      dy   = DW'(yp_q) - DW'(yk_q);
      sqx  = dx * dx;
      sqy  = dy * dy;
      s_c  = {1'b0, sqx} + {1'b0, sqy};
      sat  = |root[RTW-1:N+1];
      rk_c = sat ? '1 : root[N:0];
   end

   // The root unit is idle on the first ROOT cycle, which is what kicks it off.
   assign sq_start = (state == ROOT) && !sq_busy;
   assign in_ready = (state == IDLE);

   isqrt #(.N(N)) u_isqrt (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (sq_start),
      .radicand (s_q),
      .busy     (sq_busy),
      .done     (sq_done),
      .root     (root)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         xk_q      <= '0;
         yk_q      <= '0;
         xp_q      <= '0;
         yp_q      <= '0;
         s_q       <= '0;
         rK        <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xk_q  <= xK;
                  yk_q  <= yK;
                  xp_q  <= xP;
                  yp_q  <= yP;
                  state <= SQUARE;
               end
            end
            SQUARE: begin
               s_q   <= s_c;
               state <= ROOT;
            end
            ROOT: begin
               if (sq_done) begin
                  rK        <= rk_c;
                  ovf       <= sat;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_range_calc.sv
// Self-checking bench for range_calc: table vectors, scoreboard, and handshake/reset corners.
module tb_range_calc;

   localparam int N = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic signed [N-1:0] xK, yK;
   logic signed [N+1:0] xP, yP;
   logic                in_valid, in_ready;
   logic [N:0]          rK;
   logic                ovf, out_valid, out_ready;

   always #5 clk = ~clk;

   range_calc #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .xK        (xK),
      .yK        (yK),
      .xP        (xP),
      .yP        (yP),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rK        (rK),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      int xk; int yk; int xp; int yp; int rk; int ov;
   } vec_t;

   typedef struct {
      int rk; int ov;
   } res_t;

   res_t sbq[$];
   res_t cur_exp;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_acc = 0;
   int   n_res = 0;
   int   acc_cyc[$];
   int   res_cyc[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic res_t model(input int xk, input int yk, input int xp, input int yp);
      longint dx, dy, s, r;
      res_t   e;
      dx = longint'(xp) - longint'(xk);
      dy = longint'(yp) - longint'(yk);
      s  = dx * dx + dy * dy;
      r  = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      e.rk = (r > 511) ? 511 : int'(r);
      e.ov = (r > 511) ? 1 : 0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Accepts and results are both observed mid-cycle, ahead of the edge that completes them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            sbq.push_back(cur_exp);
            n_acc++;
            acc_cyc.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: unexpected result rK=%0d ovf=%0d, expected none", rK, ovf);
            end else begin
               res_t e;
               e = sbq.pop_front();
               check("result rK", int'(rK), e.rk);
               check("result ovf", int'(ovf), e.ov);
            end
            n_res++;
            res_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      xK = 8'(v.xk);
      yK = 8'(v.yk);
      xP = 10'(v.xp);
      yP = 10'(v.yp);
      cur_exp.rk = v.rk;
      cur_exp.ov = v.ov;
   endtask

   task automatic do_op(input vec_t v, input int hold, input string tag);
      int   k;
      int   lat;
      logic [N:0] rk0;
      logic ov0;
      k = 0;
      while (!in_ready && k < 50) begin tick(); k++; end
      check({tag, " in_ready before"}, int'(in_ready), 1);
      drive(v);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin tick(); lat++; end
      check({tag, " latency"}, lat, N + 5);
      check({tag, " in_ready busy"}, int'(in_ready), 0);
      rk0 = rK;
      ov0 = ovf;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, " hold rK"}, int'(rK), int'(rk0));
         check({tag, " hold ovf"}, int'(ovf), int'(ov0));
         check({tag, " hold out_valid"}, int'(out_valid), 1);
         check({tag, " hold in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid after"}, int'(out_valid), 0);
      check({tag, " in_ready after"}, int'(in_ready), 1);
   endtask

   initial begin
      vec_t tbl[9];
      vec_t v, va, vb;
      res_t e;
      int   k, cnt, a0, r0;

      in_valid  = 1'b0;
      out_ready = 1'b0;
      xK = '0; yK = '0; xP = '0; yP = '0;
      cur_exp.rk = 0; cur_exp.ov = 0;

      tbl[0] = '{xk: 0,    yk: 0,    xp: 3,    yp: 4,    rk: 5,   ov: 0};
      tbl[1] = '{xk: -16,  yk: -111, xp: 20,   yp: -111, rk: 36,  ov: 0};
      tbl[2] = '{xk: 0,    yk: 0,    xp: 10,   yp: 10,   rk: 14,  ov: 0};
      tbl[3] = '{xk: -128, yk: -128, xp: 511,  yp: 511,  rk: 511, ov: 1};
      tbl[4] = '{xk: 5,    yk: 5,    xp: 5,    yp: 5,    rk: 0,   ov: 0};
      tbl[5] = '{xk: 127,  yk: 127,  xp: -512, yp: -512, rk: 511, ov: 1};
      tbl[6] = '{xk: 0,    yk: 0,    xp: -511, yp: 0,    rk: 511, ov: 0};
      tbl[7] = '{xk: -1,   yk: 0,    xp: 511,  yp: 0,    rk: 511, ov: 1};
      tbl[8] = '{xk: 100,  yk: -100, xp: 200,  yp: 0,    rk: 141, ov: 0};

      repeat (3) tick();
      check("reset out_valid", int'(out_valid), 0);
      check("reset rK", int'(rK), 0);
      check("reset ovf", int'(ovf), 0);
      rst_n = 1'b1;
      tick();
      check("release in_ready", int'(in_ready), 1);

      for (int i = 0; i < 9; i++) do_op(tbl[i], 0, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         v.xk = int'($urandom_range(0, 255)) - 128;
         v.yk = int'($urandom_range(0, 255)) - 128;
         v.xp = int'($urandom_range(0, 1023)) - 512;
         v.yp = int'($urandom_range(0, 1023)) - 512;
         e = model(v.xk, v.yk, v.xp, v.yp);
         v.rk = e.rk;
         v.ov = e.ov;
         do_op(v, 0, $sformatf("rnd%0d", i));
      end

      // Stall in DONE; leaves rK=511, ovf=1 for the reset test below.
      do_op(tbl[3], 5, "stall");

      // Reset during the 4th ROOT cycle.
      drive(tbl[0]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      check("midroot out_valid", int'(out_valid), 0);
      check("midroot rK", int'(rK), 0);
      check("midroot ovf", int'(ovf), 0);
      sbq.delete();
      rst_n = 1'b1;
      tick();
      check("midroot in_ready", int'(in_ready), 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) cnt++;
      end
      check("midroot no partial", cnt, 0);
      v = '{xk: 0, yk: 0, xp: 5, yp: 12, rk: 13, ov: 0};
      do_op(v, 0, "after_reset");

      // in_valid held high across two operand sets.
      va = tbl[1];
      vb = tbl[2];
      a0 = n_acc;
      r0 = n_res;
      out_ready = 1'b1;
      drive(va);
      in_valid = 1'b1;
      k = 0;
      while (n_acc == a0 && k < 50) begin tick(); k++; end
      drive(vb);
      k = 0;
      while (n_acc < a0 + 2 && k < 60) begin tick(); k++; end
      in_valid = 1'b0;
      k = 0;
      while (n_res < r0 + 2 && k < 60) begin tick(); k++; end
      repeat (20) tick();
      out_ready = 1'b0;
      check("b2b accepts", n_acc - a0, 2);
      check("b2b results", n_res - r0, 2);
      if (acc_cyc.size() > a0 + 1 && res_cyc.size() > r0)
         check("b2b second accept gap", acc_cyc[a0 + 1] - res_cyc[r0], 1);
      else begin
         checks++;
         errors++;
         $display("FAIL b2b second accept gap: got no record, expected 1");
      end

      check("scoreboard drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
